// File: rtl/axi_arbiter_2to1_if.sv
`default_nettype none
// ============================================================================
//  Module      : axi_channel (interface)
//  Description : Full AXI4 bundle (AW/W/B/AR/R) with master and slave views.
//  Revision    : 1.0  initial release
// ============================================================================
interface axi_channel #(
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64,
  parameter int USER_WIDTH = 1
);
  // Write address channel
  logic [ID_WIDTH-1:0]     aw_id;
  logic [ADDR_WIDTH-1:0]   aw_addr;
  logic [7:0]              aw_len;
  logic [2:0]              aw_size;
  logic [1:0]              aw_burst;
  logic                    aw_lock;
  logic [3:0]              aw_cache;
  logic [2:0]              aw_prot;
  logic [3:0]              aw_qos;
  logic [3:0]              aw_region;
  logic [USER_WIDTH-1:0]   aw_user;
  logic                    aw_valid;
  logic                    aw_ready;
  // Write data channel
  logic [DATA_WIDTH-1:0]   w_data;
  logic [DATA_WIDTH/8-1:0] w_strb;
  logic                    w_last;
  logic [USER_WIDTH-1:0]   w_user;
  logic                    w_valid;
  logic                    w_ready;
  // Write response channel
  logic [ID_WIDTH-1:0]     b_id;
  logic [1:0]              b_resp;
  logic [USER_WIDTH-1:0]   b_user;
  logic                    b_valid;
  logic                    b_ready;
  // Read address channel
  logic [ID_WIDTH-1:0]     ar_id;
  logic [ADDR_WIDTH-1:0]   ar_addr;
  logic [7:0]              ar_len;
  logic [2:0]              ar_size;
  logic [1:0]              ar_burst;
  logic                    ar_lock;
  logic [3:0]              ar_cache;
  logic [2:0]              ar_prot;
  logic [3:0]              ar_qos;
  logic [3:0]              ar_region;
  logic [USER_WIDTH-1:0]   ar_user;
  logic                    ar_valid;
  logic                    ar_ready;
  // Read data channel
  logic [ID_WIDTH-1:0]     r_id;
  logic [DATA_WIDTH-1:0]   r_data;
  logic [1:0]              r_resp;
  logic                    r_last;
  logic [USER_WIDTH-1:0]   r_user;
  logic                    r_valid;
  logic                    r_ready;

  modport master (
    output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache,
           aw_prot, aw_qos, aw_region, aw_user, aw_valid,
    input  aw_ready,
    output w_data, w_strb, w_last, w_user, w_valid,
    input  w_ready,
    input  b_id, b_resp, b_user, b_valid,
    output b_ready,
    output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache,
           ar_prot, ar_qos, ar_region, ar_user, ar_valid,
    input  ar_ready,
    input  r_id, r_data, r_resp, r_last, r_user, r_valid,
    output r_ready
  );

  modport slave (
    input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache,
           aw_prot, aw_qos, aw_region, aw_user, aw_valid,
    output aw_ready,
    input  w_data, w_strb, w_last, w_user, w_valid,
    output w_ready,
    output b_id, b_resp, b_user, b_valid,
    input  b_ready,
    input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache,
           ar_prot, ar_qos, ar_region, ar_user, ar_valid,
    output ar_ready,
    output r_id, r_data, r_resp, r_last, r_user, r_valid,
    input  r_ready
  );
endinterface
`default_nettype wire

// File: rtl/axi_arbiter_2to1.sv
`default_nettype none
// ============================================================================
//  Module      : axi_arbiter_2to1
//  Description : Two-master to one-slave AXI4 arbiter. Independent round-robin
//                on AW and AR, W ordered by AW grant order through a small
//                index FIFO, B/R routed back by the ID MSB (source index).
//  Revision    : 1.0  initial release
// ============================================================================
module axi_arbiter_2to1 #(
  parameter int ID_WIDTH     = 4,
  parameter int ADDR_WIDTH   = 64,
  parameter int DATA_WIDTH   = 64,
  parameter int USER_WIDTH   = 1,
  parameter int W_FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  axi_channel.slave  master0,
  axi_channel.slave  master1,
  axi_channel.master outgoing
);

  localparam int PTR_W = (W_FIFO_DEPTH > 1) ? $clog2(W_FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(W_FIFO_DEPTH + 1);

  // --------------------------------------------------------------------------
  // Write-index FIFO state (one bit per entry: which master owns the burst)
  // --------------------------------------------------------------------------
  logic [W_FIFO_DEPTH-1:0] fifo_mem;
  logic [PTR_W-1:0]        fifo_wr_ptr;
  logic [PTR_W-1:0]        fifo_rd_ptr;
  logic [CNT_W-1:0]        fifo_cnt;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic                    fifo_head;
  logic                    fifo_push;
  logic                    fifo_pop;

  assign fifo_full  = (fifo_cnt == CNT_W'(W_FIFO_DEPTH));
  assign fifo_empty = (fifo_cnt == '0);
  assign fifo_head  = fifo_mem[fifo_rd_ptr];

  // --------------------------------------------------------------------------
  // AW arbitration
  // --------------------------------------------------------------------------
  logic                  aw_ptr;       // master favoured when both request
  logic                  aw_locked;    // grant held until the pending handshake
  logic                  aw_lock_idx;
  logic                  aw_sel;
  logic                  aw_any;
  logic                  aw_go;
  logic                  aw_fire;
  logic [ID_WIDTH-1:0]   aw_id_mux;
  logic [ADDR_WIDTH-1:0] aw_addr_mux;

  // Choose the AW source: a held grant wins, otherwise round-robin among requesters
  always_comb begin
    aw_sel = 1'b0;
    aw_any = 1'b0;
    if (aw_locked) begin
      aw_sel = aw_lock_idx;
      aw_any = aw_lock_idx ? master1.aw_valid : master0.aw_valid;
    end else if (master0.aw_valid && master1.aw_valid) begin
      aw_sel = aw_ptr;
      aw_any = 1'b1;
    end else begin
      aw_sel = master1.aw_valid;
      aw_any = master0.aw_valid | master1.aw_valid;
    end
  end

  // A full FIFO would lose the W ordering record, so AW is withheld entirely
  assign aw_go   = aw_any && !fifo_full && !rst;
  assign aw_fire = aw_go && outgoing.aw_ready;

  assign aw_id_mux   = aw_sel ? master1.aw_id   : master0.aw_id;
  assign aw_addr_mux = aw_sel ? master1.aw_addr : master0.aw_addr;

  assign outgoing.aw_valid  = aw_go;
  assign outgoing.aw_id     = {aw_sel, aw_id_mux};
  assign outgoing.aw_addr   = aw_addr_mux;
  assign outgoing.aw_len    = aw_sel ? master1.aw_len    : master0.aw_len;
  assign outgoing.aw_size   = aw_sel ? master1.aw_size   : master0.aw_size;
  assign outgoing.aw_burst  = aw_sel ? master1.aw_burst  : master0.aw_burst;
  assign outgoing.aw_lock   = aw_sel ? master1.aw_lock   : master0.aw_lock;
  assign outgoing.aw_cache  = aw_sel ? master1.aw_cache  : master0.aw_cache;
  assign outgoing.aw_prot   = aw_sel ? master1.aw_prot   : master0.aw_prot;
  assign outgoing.aw_qos    = aw_sel ? master1.aw_qos    : master0.aw_qos;
  assign outgoing.aw_region = aw_sel ? master1.aw_region : master0.aw_region;
  assign outgoing.aw_user   = aw_sel ? master1.aw_user   : master0.aw_user;

  assign master0.aw_ready = aw_go && !aw_sel && outgoing.aw_ready;
  assign master1.aw_ready = aw_go &&  aw_sel && outgoing.aw_ready;

  // AW pointer moves away from the winner on handshake; a stalled grant is locked
  always_ff @(posedge clk) begin
    if (rst) begin
      aw_ptr      <= 1'b0;
      aw_locked   <= 1'b0;
      aw_lock_idx <= 1'b0;
    end else if (aw_fire) begin
      aw_ptr      <= ~aw_sel;
      aw_locked   <= 1'b0;
    end else if (aw_go) begin
      aw_locked   <= 1'b1;
      aw_lock_idx <= aw_sel;
    end
  end

  // --------------------------------------------------------------------------
  // W routing: FIFO head selects the only master allowed to send data
  // --------------------------------------------------------------------------
  logic                    w_src_valid;
  logic                    w_go;
  logic                    w_last_mux;
  logic [DATA_WIDTH-1:0]   w_data_mux;
  logic [DATA_WIDTH/8-1:0] w_strb_mux;
  logic [USER_WIDTH-1:0]   w_user_mux;

  assign w_src_valid = fifo_head ? master1.w_valid : master0.w_valid;
  assign w_go        = !fifo_empty && w_src_valid && !rst;
  assign w_last_mux  = fifo_head ? master1.w_last : master0.w_last;
  assign w_data_mux  = fifo_head ? master1.w_data : master0.w_data;
  assign w_strb_mux  = fifo_head ? master1.w_strb : master0.w_strb;
  assign w_user_mux  = fifo_head ? master1.w_user : master0.w_user;

  assign outgoing.w_valid = w_go;
  assign outgoing.w_data  = w_data_mux;
  assign outgoing.w_strb  = w_strb_mux;
  assign outgoing.w_last  = w_last_mux;
  assign outgoing.w_user  = w_user_mux;

  assign master0.w_ready = !fifo_empty && !fifo_head && outgoing.w_ready && !rst;
  assign master1.w_ready = !fifo_empty &&  fifo_head && outgoing.w_ready && !rst;

  assign fifo_push = aw_fire;
  assign fifo_pop  = w_go && outgoing.w_ready && w_last_mux;

  // Index FIFO: record AW grant order, retire an entry on the burst's last beat
  always_ff @(posedge clk) begin
    if (rst) begin
      fifo_mem    <= '0;
      fifo_wr_ptr <= '0;
      fifo_rd_ptr <= '0;
      fifo_cnt    <= '0;
    end else begin
      if (fifo_push) begin
        fifo_mem[fifo_wr_ptr] <= aw_sel;
        fifo_wr_ptr           <= fifo_wr_ptr + 1'b1;
      end
      if (fifo_pop) begin
        fifo_rd_ptr <= fifo_rd_ptr + 1'b1;
      end
      case ({fifo_push, fifo_pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // AR arbitration: same round-robin and lock scheme, no ordering FIFO
  // --------------------------------------------------------------------------
  logic                  ar_ptr;
  logic                  ar_locked;
  logic                  ar_lock_idx;
  logic                  ar_sel;
  logic                  ar_any;
  logic                  ar_go;
  logic [ID_WIDTH-1:0]   ar_id_mux;
  logic [ADDR_WIDTH-1:0] ar_addr_mux;

  // Choose the AR source with the same rules as AW
  always_comb begin
    ar_sel = 1'b0;
    ar_any = 1'b0;
    if (ar_locked) begin
      ar_sel = ar_lock_idx;
      ar_any = ar_lock_idx ? master1.ar_valid : master0.ar_valid;
    end else if (master0.ar_valid && master1.ar_valid) begin
      ar_sel = ar_ptr;
      ar_any = 1'b1;
    end else begin
      ar_sel = master1.ar_valid;
      ar_any = master0.ar_valid | master1.ar_valid;
    end
  end

  assign ar_go       = ar_any && !rst;
  assign ar_id_mux   = ar_sel ? master1.ar_id   : master0.ar_id;
  assign ar_addr_mux = ar_sel ? master1.ar_addr : master0.ar_addr;

  assign outgoing.ar_valid  = ar_go;
  assign outgoing.ar_id     = {ar_sel, ar_id_mux};
  assign outgoing.ar_addr   = ar_addr_mux;
  assign outgoing.ar_len    = ar_sel ? master1.ar_len    : master0.ar_len;
  assign outgoing.ar_size   = ar_sel ? master1.ar_size   : master0.ar_size;
  assign outgoing.ar_burst  = ar_sel ? master1.ar_burst  : master0.ar_burst;
  assign outgoing.ar_lock   = ar_sel ? master1.ar_lock   : master0.ar_lock;
  assign outgoing.ar_cache  = ar_sel ? master1.ar_cache  : master0.ar_cache;
  assign outgoing.ar_prot   = ar_sel ? master1.ar_prot   : master0.ar_prot;
  assign outgoing.ar_qos    = ar_sel ? master1.ar_qos    : master0.ar_qos;
  assign outgoing.ar_region = ar_sel ? master1.ar_region : master0.ar_region;
  assign outgoing.ar_user   = ar_sel ? master1.ar_user   : master0.ar_user;

  assign master0.ar_ready = ar_go && !ar_sel && outgoing.ar_ready;
  assign master1.ar_ready = ar_go &&  ar_sel && outgoing.ar_ready;

  // AR pointer and grant lock, updated independently of the write side
  always_ff @(posedge clk) begin
    if (rst) begin
      ar_ptr      <= 1'b0;
      ar_locked   <= 1'b0;
      ar_lock_idx <= 1'b0;
    end else if (ar_go && outgoing.ar_ready) begin
      ar_ptr      <= ~ar_sel;
      ar_locked   <= 1'b0;
    end else if (ar_go) begin
      ar_locked   <= 1'b1;
      ar_lock_idx <= ar_sel;
    end
  end

  // --------------------------------------------------------------------------
  // B / R return: ID MSB names the destination master, the rest is its ID
  // --------------------------------------------------------------------------
  logic b_dst;
  logic r_dst;

  assign b_dst = outgoing.b_id[ID_WIDTH];
  assign r_dst = outgoing.r_id[ID_WIDTH];

  assign master0.b_valid = outgoing.b_valid && !b_dst && !rst;
  assign master1.b_valid = outgoing.b_valid &&  b_dst && !rst;
  assign master0.b_id    = outgoing.b_id[ID_WIDTH-1:0];
  assign master1.b_id    = outgoing.b_id[ID_WIDTH-1:0];
  assign master0.b_resp  = outgoing.b_resp;
  assign master1.b_resp  = outgoing.b_resp;
  assign master0.b_user  = outgoing.b_user;
  assign master1.b_user  = outgoing.b_user;
  assign outgoing.b_ready = !rst && (b_dst ? master1.b_ready : master0.b_ready);

  assign master0.r_valid = outgoing.r_valid && !r_dst && !rst;
  assign master1.r_valid = outgoing.r_valid &&  r_dst && !rst;
  assign master0.r_id    = outgoing.r_id[ID_WIDTH-1:0];
  assign master1.r_id    = outgoing.r_id[ID_WIDTH-1:0];
  assign master0.r_data  = outgoing.r_data;
  assign master1.r_data  = outgoing.r_data;
  assign master0.r_resp  = outgoing.r_resp;
  assign master1.r_resp  = outgoing.r_resp;
  assign master0.r_last  = outgoing.r_last;
  assign master1.r_last  = outgoing.r_last;
  assign master0.r_user  = outgoing.r_user;
  assign master1.r_user  = outgoing.r_user;
  assign outgoing.r_ready = !rst && (r_dst ? master1.r_ready : master0.r_ready);

endmodule
`default_nettype wire

// File: tb/tb_axi_arbiter_2to1.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axi_arbiter_2to1
//  Description : Randomized bench for axi_arbiter_2to1 against a queue-based
//                reference model of grant order, W ordering and ID routing.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_axi_arbiter_2to1;
  localparam int IDW   = 4;
  localparam int AW    = 64;
  localparam int DW    = 64;
  localparam int UW    = 1;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axi_channel #(.ID_WIDTH(IDW),   .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .USER_WIDTH(UW)) m0_if ();
  axi_channel #(.ID_WIDTH(IDW),   .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .USER_WIDTH(UW)) m1_if ();
  axi_channel #(.ID_WIDTH(IDW+1), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .USER_WIDTH(UW)) out_if ();

  axi_arbiter_2to1 #(
    .ID_WIDTH(IDW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .USER_WIDTH(UW), .W_FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .master0(m0_if), .master1(m1_if), .outgoing(out_if)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Master-side stimulus
  logic           awv[2];
  logic [IDW-1:0] awid[2];
  logic [AW-1:0]  awaddr[2];
  logic [7:0]     awlen[2];
  logic           wv[2];
  logic [DW-1:0]  wdata[2];
  logic           wlast[2];
  logic           arv[2];
  logic [IDW-1:0] arid[2];
  logic [AW-1:0]  araddr[2];
  logic           brdy[2];
  logic           rrdy[2];
  bit             aw_hs[2];
  bit             w_hs[2];
  bit             ar_hs[2];
  // Slave-side stimulus
  logic           s_aw_rdy, s_w_rdy, s_ar_rdy, s_b_v, s_r_v, s_r_last;
  logic [IDW:0]   s_b_id, s_r_id;
  logic [DW-1:0]  s_r_data;
  // Stimulus probabilities in percent
  int p_aw[2], p_w[2], p_ar[2];
  int p_awr, p_wr, p_arr, p_last, p_resp;
  // Reference model
  int fav_aw, held_aw, fav_ar, held_ar;
  int wq[$];

  assign m0_if.aw_valid = awv[0];   assign m1_if.aw_valid = awv[1];
  assign m0_if.aw_id    = awid[0];  assign m1_if.aw_id    = awid[1];
  assign m0_if.aw_addr  = awaddr[0];assign m1_if.aw_addr  = awaddr[1];
  assign m0_if.aw_len   = awlen[0]; assign m1_if.aw_len   = awlen[1];
  assign m0_if.aw_size  = 3'd3;     assign m1_if.aw_size  = 3'd3;
  assign m0_if.aw_burst = 2'd1;     assign m1_if.aw_burst = 2'd1;
  assign m0_if.aw_lock  = 1'b0;     assign m1_if.aw_lock  = 1'b0;
  assign m0_if.aw_cache = 4'd0;     assign m1_if.aw_cache = 4'd0;
  assign m0_if.aw_prot  = 3'd0;     assign m1_if.aw_prot  = 3'd0;
  assign m0_if.aw_qos   = 4'd0;     assign m1_if.aw_qos   = 4'd0;
  assign m0_if.aw_region= 4'd0;     assign m1_if.aw_region= 4'd0;
  assign m0_if.aw_user  = '0;       assign m1_if.aw_user  = '0;
  assign m0_if.w_valid  = wv[0];    assign m1_if.w_valid  = wv[1];
  assign m0_if.w_data   = wdata[0]; assign m1_if.w_data   = wdata[1];
  assign m0_if.w_strb   = '1;       assign m1_if.w_strb   = '1;
  assign m0_if.w_last   = wlast[0]; assign m1_if.w_last   = wlast[1];
  assign m0_if.w_user   = '0;       assign m1_if.w_user   = '0;
  assign m0_if.b_ready  = brdy[0];  assign m1_if.b_ready  = brdy[1];
  assign m0_if.ar_valid = arv[0];   assign m1_if.ar_valid = arv[1];
  assign m0_if.ar_id    = arid[0];  assign m1_if.ar_id    = arid[1];
  assign m0_if.ar_addr  = araddr[0];assign m1_if.ar_addr  = araddr[1];
  assign m0_if.ar_len   = 8'd0;     assign m1_if.ar_len   = 8'd0;
  assign m0_if.ar_size  = 3'd3;     assign m1_if.ar_size  = 3'd3;
  assign m0_if.ar_burst = 2'd1;     assign m1_if.ar_burst = 2'd1;
  assign m0_if.ar_lock  = 1'b0;     assign m1_if.ar_lock  = 1'b0;
  assign m0_if.ar_cache = 4'd0;     assign m1_if.ar_cache = 4'd0;
  assign m0_if.ar_prot  = 3'd0;     assign m1_if.ar_prot  = 3'd0;
  assign m0_if.ar_qos   = 4'd0;     assign m1_if.ar_qos   = 4'd0;
  assign m0_if.ar_region= 4'd0;     assign m1_if.ar_region= 4'd0;
  assign m0_if.ar_user  = '0;       assign m1_if.ar_user  = '0;
  assign m0_if.r_ready  = rrdy[0];  assign m1_if.r_ready  = rrdy[1];

  assign out_if.aw_ready = s_aw_rdy;
  assign out_if.w_ready  = s_w_rdy;
  assign out_if.ar_ready = s_ar_rdy;
  assign out_if.b_valid  = s_b_v;
  assign out_if.b_id     = s_b_id;
  assign out_if.b_resp   = 2'd0;
  assign out_if.b_user   = '0;
  assign out_if.r_valid  = s_r_v;
  assign out_if.r_id     = s_r_id;
  assign out_if.r_data   = s_r_data;
  assign out_if.r_resp   = 2'd0;
  assign out_if.r_last   = s_r_last;
  assign out_if.r_user   = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit roll(input int pct);
    return ($urandom_range(99) < pct);
  endfunction

  // Round-robin rule: a held grant stays; both -> favoured; one -> that one
  function automatic int pick(input int held, input logic v0, input logic v1, input int fav);
    if (held >= 0) return held;
    if (v0 && v1)  return fav;
    if (v0)        return 0;
    if (v1)        return 1;
    return -1;
  endfunction

  task automatic clear_stim();
    for (int k = 0; k < 2; k++) begin
      awv[k] = 0; awid[k] = '0; awaddr[k] = '0; awlen[k] = '0;
      wv[k] = 0; wdata[k] = '0; wlast[k] = 0;
      arv[k] = 0; arid[k] = '0; araddr[k] = '0;
      brdy[k] = 0; rrdy[k] = 0;
      aw_hs[k] = 0; w_hs[k] = 0; ar_hs[k] = 0;
    end
    s_aw_rdy = 0; s_w_rdy = 0; s_ar_rdy = 0; s_b_v = 0; s_r_v = 0; s_r_last = 0;
    s_b_id = '0; s_r_id = '0; s_r_data = '0;
  endtask

  task automatic set_knobs(input int aw0, input int aw1, input int w0, input int w1,
                           input int ar0, input int ar1, input int awr, input int wr,
                           input int arr, input int last, input int resp);
    p_aw[0] = aw0; p_aw[1] = aw1; p_w[0] = w0; p_w[1] = w1; p_ar[0] = ar0; p_ar[1] = ar1;
    p_awr = awr; p_wr = wr; p_arr = arr; p_last = last; p_resp = resp;
  endtask

  // One reset cycle: everything quiet, outputs must be idle, model returns to reset
  task automatic reset_cycle();
    @(posedge clk); #1;
    rst = 1'b1;
    clear_stim();
    #3;
    check("rst_out_aw_valid", 64'(out_if.aw_valid), 64'(0));
    check("rst_out_w_valid",  64'(out_if.w_valid),  64'(0));
    check("rst_out_ar_valid", 64'(out_if.ar_valid), 64'(0));
    check("rst_out_b_ready",  64'(out_if.b_ready),  64'(0));
    check("rst_out_r_ready",  64'(out_if.r_ready),  64'(0));
    check("rst_m_aw_ready",   64'({m0_if.aw_ready, m1_if.aw_ready}), 64'(0));
    check("rst_m_w_ready",    64'({m0_if.w_ready,  m1_if.w_ready}),  64'(0));
    check("rst_m_ar_ready",   64'({m0_if.ar_ready, m1_if.ar_ready}), 64'(0));
    check("rst_m_b_valid",    64'({m0_if.b_valid,  m1_if.b_valid}),  64'(0));
    check("rst_m_r_valid",    64'({m0_if.r_valid,  m1_if.r_valid}),  64'(0));
    fav_aw = 0; held_aw = -1; fav_ar = 0; held_ar = -1;
    wq.delete();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // One clock: drive new stimulus, compare DUT to the model, advance the model
  task automatic step();
    int  ga, gr, hd, bd, rd;
    bit  eaw, ear, ew;
    @(posedge clk); #1;
    for (int k = 0; k < 2; k++) begin
      if (aw_hs[k] || !awv[k]) begin
        awv[k] = roll(p_aw[k]); awid[k] = IDW'($urandom);
        awaddr[k] = {$urandom, $urandom}; awlen[k] = 8'($urandom); aw_hs[k] = 0;
      end
      if (w_hs[k] || !wv[k]) begin
        wv[k] = roll(p_w[k]); wdata[k] = {$urandom, $urandom}; wlast[k] = roll(p_last); w_hs[k] = 0;
      end
      if (ar_hs[k] || !arv[k]) begin
        arv[k] = roll(p_ar[k]); arid[k] = IDW'($urandom);
        araddr[k] = {$urandom, $urandom}; ar_hs[k] = 0;
      end
      brdy[k] = roll(p_resp); rrdy[k] = roll(p_resp);
    end
    s_aw_rdy = roll(p_awr); s_w_rdy = roll(p_wr); s_ar_rdy = roll(p_arr);
    s_b_v = roll(p_resp); s_b_id = (IDW+1)'($urandom);
    s_r_v = roll(p_resp); s_r_id = (IDW+1)'($urandom);
    s_r_data = {$urandom, $urandom}; s_r_last = roll(50);
    #3;

    // AW
    ga  = pick(held_aw, awv[0], awv[1], fav_aw);
    eaw = (ga >= 0) && (wq.size() < DEPTH);
    check("aw_valid", 64'(out_if.aw_valid), 64'(eaw));
    if (eaw) begin
      check("aw_id",   64'(out_if.aw_id),   64'({ga[0], awid[ga]}));
      check("aw_addr", 64'(out_if.aw_addr), 64'(awaddr[ga]));
      check("aw_len",  64'(out_if.aw_len),  64'(awlen[ga]));
    end
    check("m0_aw_ready", 64'(m0_if.aw_ready), 64'(eaw && ga == 0 && s_aw_rdy));
    check("m1_aw_ready", 64'(m1_if.aw_ready), 64'(eaw && ga == 1 && s_aw_rdy));

    // W
    hd = (wq.size() > 0) ? wq[0] : -1;
    ew = (hd >= 0) ? wv[hd] : 1'b0;
    check("w_valid", 64'(out_if.w_valid), 64'(ew));
    if (ew) begin
      check("w_data", 64'(out_if.w_data), 64'(wdata[hd]));
      check("w_last", 64'(out_if.w_last), 64'(wlast[hd]));
    end
    check("m0_w_ready", 64'(m0_if.w_ready), 64'(hd == 0 && s_w_rdy));
    check("m1_w_ready", 64'(m1_if.w_ready), 64'(hd == 1 && s_w_rdy));

    // AR
    gr  = pick(held_ar, arv[0], arv[1], fav_ar);
    ear = (gr >= 0);
    check("ar_valid", 64'(out_if.ar_valid), 64'(ear));
    if (ear) begin
      check("ar_id",   64'(out_if.ar_id),   64'({gr[0], arid[gr]}));
      check("ar_addr", 64'(out_if.ar_addr), 64'(araddr[gr]));
    end
    check("m0_ar_ready", 64'(m0_if.ar_ready), 64'(ear && gr == 0 && s_ar_rdy));
    check("m1_ar_ready", 64'(m1_if.ar_ready), 64'(ear && gr == 1 && s_ar_rdy));

    // B / R routing by ID MSB
    bd = int'(s_b_id[IDW]);
    rd = int'(s_r_id[IDW]);
    check("m0_b_valid", 64'(m0_if.b_valid), 64'(s_b_v && bd == 0));
    check("m1_b_valid", 64'(m1_if.b_valid), 64'(s_b_v && bd == 1));
    check("out_b_ready", 64'(out_if.b_ready), 64'(brdy[bd]));
    if (s_b_v) check("b_id", 64'(bd ? m1_if.b_id : m0_if.b_id), 64'(s_b_id[IDW-1:0]));
    check("m0_r_valid", 64'(m0_if.r_valid), 64'(s_r_v && rd == 0));
    check("m1_r_valid", 64'(m1_if.r_valid), 64'(s_r_v && rd == 1));
    check("out_r_ready", 64'(out_if.r_ready), 64'(rrdy[rd]));
    if (s_r_v) begin
      check("r_id",   64'(rd ? m1_if.r_id : m0_if.r_id),     64'(s_r_id[IDW-1:0]));
      check("r_data", 64'(rd ? m1_if.r_data : m0_if.r_data), 64'(s_r_data));
      check("r_last", 64'(rd ? m1_if.r_last : m0_if.r_last), 64'(s_r_last));
    end

    // Advance model: W retires with the pre-push queue, then AW pushes
    if (hd >= 0 && wv[hd] && s_w_rdy) begin
      w_hs[hd] = 1;
      if (wlast[hd]) void'(wq.pop_front());
    end
    if (eaw && s_aw_rdy) begin
      wq.push_back(ga); fav_aw = 1 - ga; held_aw = -1; aw_hs[ga] = 1;
    end else if (eaw) begin
      held_aw = ga;
    end
    if (ear && s_ar_rdy) begin
      fav_ar = 1 - gr; held_ar = -1; ar_hs[gr] = 1;
    end else if (ear) begin
      held_ar = gr;
    end
  endtask

  initial begin
    clear_stim();
    set_knobs(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    reset_cycle();
    reset_cycle();

    // Both masters stream AW with an always-ready slave: grants alternate
    set_knobs(100, 100, 100, 100, 0, 0, 100, 100, 100, 50, 50);
    repeat (16) step();

    // master1 held against a stalled slave, master0 joins later
    set_knobs(0, 100, 0, 0, 0, 0, 0, 100, 100, 50, 50);
    repeat (5) step();
    p_aw[0] = 100;
    repeat (2) step();
    p_awr = 100;
    repeat (4) step();

    // W refused: index FIFO fills and AW stalls, then bursts drain
    set_knobs(100, 100, 100, 100, 0, 0, 100, 0, 100, 50, 50);
    repeat (8) step();
    p_wr = 100; p_last = 100;
    repeat (8) step();

    // master0 alone issues back-to-back reads
    set_knobs(0, 0, 0, 0, 100, 0, 100, 100, 100, 50, 100);
    repeat (4) step();

    // Random traffic, then a reset in the middle of it
    set_knobs(50, 50, 60, 60, 50, 50, 60, 60, 60, 35, 50);
    repeat (150) step();
    reset_cycle();
    set_knobs(100, 100, 0, 0, 100, 100, 100, 100, 100, 50, 50);
    repeat (3) step();

    // Random traffic with a slow W sink so the FIFO spends time full
    set_knobs(60, 60, 70, 70, 50, 50, 60, 15, 40, 40, 50);
    repeat (200) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
